// File: rtl/io_input_conditioner.sv
// io_input_conditioner
//
// Purpose:
//   Cleans up the raw, asynchronous board inputs (slide switches and the GPIO
//   input header) before they reach the memory-mapped IO block's read window.
//   Every bit passes through a two-flop synchroniser and then its own debounce
//   counter. A new level is accepted only after it has been seen for
//   DEBOUNCE_CYCLES consecutive evaluations. The block also provides a
//   one-cycle change pulse and sticky per-bit rising-edge flags, so polling
//   software can detect events it might otherwise miss.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   switches_raw in   raw slide-switch pins (asynchronous)
//   gpio_raw     in   raw GPIO header pins (asynchronous)
//   switches     out  debounced switch values
//   gpio_clean   out  debounced GPIO values
//   rise_flags   out  sticky rising-edge flags, {switches, gpio} bit order
//   flags_clr    in   clears every rise flag (a coincident new rise still sets)
//   change_pulse out  high for one cycle, the first cycle an updated value is visible
//
// Parameters:
//   SW_W, GPIO_W     input widths
//   DEBOUNCE_CYCLES  consecutive evaluations a differing level must persist (>=1)
//   CNT_W            counter width; must be able to hold DEBOUNCE_CYCLES-1

module io_input_conditioner #(
  parameter int SW_W            = 4,
  parameter int GPIO_W          = 36,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SW_W-1:0]          switches_raw,
  input  logic [GPIO_W-1:0]        gpio_raw,
  output logic [SW_W-1:0]          switches,
  output logic [GPIO_W-1:0]        gpio_clean,
  output logic [SW_W+GPIO_W-1:0]   rise_flags,
  input  logic                     flags_clr,
  output logic                     change_pulse
);

  localparam int N = SW_W + GPIO_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N-1:0]     rawBits;
  logic [N-1:0]     sync1_q;
  logic [N-1:0]     sync2_q;
  logic [N-1:0]     stable_q;
  logic [N-1:0]     stable_d;
  logic [N-1:0]     updateBits;
  logic [N-1:0]     flags_q;
  logic [N-1:0]     flags_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic             pulse_q;
  logic             pulse_d;

  assign rawBits = {switches_raw, gpio_raw};

  // Per-bit debounce. The count only advances while the synchronised level
  // differs from the accepted level. Any return to the accepted level restarts
  // the count, so short glitches are rejected. The last count step both
  // accepts the new level and rearms the counter.
  always_comb begin
    stable_d   = stable_q;
    updateBits = '0;
    cnt_d      = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i]   = sync2_q[i];
        updateBits[i] = 1'b1;
        cnt_d[i]      = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Flags are sticky. A rise that completes on the same edge as a clear must
  // survive that clear, so the set term is ORed in after the clear mask.
  // The change pulse is computed from the same update vector, so it appears
  // together with the new stable value. Simultaneous updates merge into one pulse.
  always_comb begin
    flags_d = (flags_q & ~{N{flags_clr}}) | (updateBits & sync2_q);
    pulse_d = |updateBits;
  end

  // All state lives in one clocked block. Reset discards any in-progress
  // count and clears the synchronisers, so debouncing restarts from scratch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      flags_q  <= '0;
      pulse_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= rawBits;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      flags_q  <= flags_d;
      pulse_q  <= pulse_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign switches     = stable_q[N-1:GPIO_W];
  assign gpio_clean   = stable_q[GPIO_W-1:0];
  assign rise_flags   = flags_q;
  assign change_pulse = pulse_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// tb_io_input_conditioner
//
// Purpose:
//   Self-checking bench for io_input_conditioner, run with DEBOUNCE_CYCLES=4.
//   Stimulus steps schedule their expected outputs into a scoreboard queue.
//   Each entry is tagged with the absolute clock edge at which it applies.
//   A negedge checker pops every due entry and compares it against the DUT.

module tb_io_input_conditioner;

  localparam int D   = 4;
  localparam int LAT = D + 2;
  localparam int N   = 40;
  localparam logic [N-1:0] ALL1 = {N{1'b1}};

  typedef struct {
    int           due;
    string        tag;
    logic [N-1:0] expStable;
    logic [N-1:0] expFlags;
    logic         expPulse;
  } ExpItem;

  logic        clk;
  logic        rst;
  logic [3:0]  switches_raw;
  logic [35:0] gpio_raw;
  logic [3:0]  switches;
  logic [35:0] gpio_clean;
  logic [39:0] rise_flags;
  logic        flags_clr;
  logic        change_pulse;

  ExpItem       sb[$];
  int           cycleCount;
  int           compareCount;
  int           mismatchCount;
  logic [N-1:0] s;
  logic [N-1:0] f;

  io_input_conditioner #(
    .SW_W(4),
    .GPIO_W(36),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .switches_raw(switches_raw),
    .gpio_raw(gpio_raw),
    .switches(switches),
    .gpio_clean(gpio_clean),
    .rise_flags(rise_flags),
    .flags_clr(flags_clr),
    .change_pulse(change_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute edge counter that scoreboard due-times refer to.
  initial cycleCount = 0;
  always @(posedge clk) cycleCount = cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", tag, observed, expected, cycleCount);
    end
  endtask

  // Schedule an expectation a number of edges after the current one, keeping the queue ordered.
  task automatic expectAt(input int offset, input string tag, input logic [N-1:0] es, input logic [N-1:0] ef, input logic ep);
    ExpItem it;
    int pos;
    it.due       = cycleCount + offset;
    it.tag       = tag;
    it.expStable = es;
    it.expFlags  = ef;
    it.expPulse  = ep;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].due > it.due) pos--;
    sb.insert(pos, it);
  endtask

  task automatic applyStimulus(input logic [3:0] sw, input logic [35:0] gp);
    @(negedge clk);
    switches_raw = sw;
    gpio_raw     = gp;
  endtask

  task automatic tickN(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain(input int maxCycles);
    int waited;
    waited = 0;
    while (sb.size() > 0 && waited < maxCycles) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      checkOutput("drain_timeout", N'(sb.size()), '0);
      sb.delete();
    end
  endtask

  // Scoreboard consumer: compare every entry whose edge has arrived.
  always @(negedge clk) begin
    ExpItem it;
    while (sb.size() > 0 && sb[0].due <= cycleCount) begin
      it = sb.pop_front();
      if (it.due < cycleCount)
        checkOutput($sformatf("%s_late", it.tag), N'(cycleCount), N'(it.due));
      checkOutput($sformatf("%s_stable", it.tag), {switches, gpio_clean}, it.expStable);
      checkOutput($sformatf("%s_flags", it.tag), rise_flags, it.expFlags);
      checkOutput($sformatf("%s_pulse", it.tag), {39'b0, change_pulse}, {39'b0, it.expPulse});
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst           = 1'b1;
    flags_clr     = 1'b0;
    switches_raw  = '0;
    gpio_raw      = '0;
    s = '0;
    f = '0;

    // Reset state
    tickN(3);
    expectAt(1, "reset", '0, '0, 1'b0);
    rst = 1'b0;
    waitDrain(20);

    // Single rise on gpio[5]: exact latency, one pulse, flag set
    applyStimulus(4'h0, 36'h0_0000_0020);
    expectAt(LAT-1, "t1_before", s, f, 1'b0);
    s = 40'h20;
    f = 40'h20;
    expectAt(LAT,   "t1_update", s, f, 1'b1);
    expectAt(LAT+1, "t1_after",  s, f, 1'b0);
    waitDrain(40);

    // Three-cycle glitch on switch[2] is rejected
    applyStimulus(4'h4, 36'h0_0000_0020);
    for (int k = 1; k <= 10; k++) expectAt(k, "t2_glitch", s, f, 1'b0);
    tickN(3);
    switches_raw = 4'h0;
    waitDrain(40);

    // Reset in the middle of a debounce on gpio[0]
    applyStimulus(4'h0, 36'h0_0000_0021);
    expectAt(3, "t5_pre", s, f, 1'b0);
    tickN(4);
    rst = 1'b1;
    expectAt(1, "t5_in_reset1", '0, '0, 1'b0);
    expectAt(2, "t5_in_reset2", '0, '0, 1'b0);
    tickN(2);
    rst = 1'b0;
    expectAt(LAT-1, "t5_before", '0, '0, 1'b0);
    s = 40'h21;
    f = 40'h21;
    expectAt(LAT,   "t5_update", s, f, 1'b1);
    expectAt(LAT+1, "t5_after",  s, f, 1'b0);
    waitDrain(40);

    // All bits rise together: one update edge, one pulse, all flags set
    applyStimulus(4'hF, 36'hF_FFFF_FFFF);
    expectAt(LAT-1, "t3_before", s, f, 1'b0);
    s = ALL1;
    f = ALL1;
    expectAt(LAT,   "t3_update", s, f, 1'b1);
    expectAt(LAT+1, "t3_after",  s, f, 1'b0);
    waitDrain(40);

    // Drop gpio[0] so it can rise again; the fall leaves the flags alone
    applyStimulus(4'hF, 36'hF_FFFF_FFFE);
    s = ALL1 & ~40'h1;
    expectAt(LAT,   "t4_fall",       s, f, 1'b1);
    expectAt(LAT+1, "t4_fall_after", s, f, 1'b0);
    waitDrain(40);

    // Clear coincides with the completing rise on bit 0: set wins
    applyStimulus(4'hF, 36'hF_FFFF_FFFF);
    tickN(LAT-1);
    flags_clr = 1'b1;
    s = ALL1;
    f = 40'h1;
    expectAt(1, "t4_set_wins", s, f, 1'b1);
    tickN(1);
    flags_clr = 1'b0;
    expectAt(1, "t4_after", s, f, 1'b0);
    waitDrain(20);

    // Falling edge on gpio[10]
    applyStimulus(4'hF, 36'hF_FFFF_FBFF);
    expectAt(LAT-1, "t6_before", s, f, 1'b0);
    s = ALL1 & ~(40'h1 << 10);
    expectAt(LAT,   "t6_update", s, f, 1'b1);
    expectAt(LAT+1, "t6_after",  s, f, 1'b0);
    waitDrain(40);

    // Plain clear with no coincident rise
    @(negedge clk);
    flags_clr = 1'b1;
    f = '0;
    expectAt(1, "t7_clear", s, f, 1'b0);
    tickN(1);
    flags_clr = 1'b0;
    expectAt(2, "t7_hold", s, f, 1'b0);
    waitDrain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
